cmp_arbiter: RTL and testbench
==============================

CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter XLEN, default 32, SHALL set operand width.
REQ-002 Parameter CMP_SEL_WIDTH, default 2, SHALL make compare-select width CMP_SEL_WIDTH+1 bits.
REQ-003 i_Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_Reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 i_Req_Valid  input  2  SHALL carry the per-requester request valid; bit r is requester r.
REQ-006 o_Req_Ready  output  2  SHALL carry the per-requester grant/accept, one-hot or zero.
REQ-007 i_Req_A  input  2*XLEN  SHALL carry operand A; slice [r*XLEN +: XLEN] belongs to requester r.
REQ-008 i_Req_B  input  2*XLEN  SHALL carry operand B, sliced as i_Req_A.
REQ-009 i_Req_Select  input  2*(CMP_SEL_WIDTH+1)  SHALL carry the compare select per requester.
REQ-010 o_Resp_Valid  output  2  SHALL carry the per-requester response valid.
REQ-011 o_Resp_Result  output  2  SHALL carry the per-requester registered 1-bit compare result.
REQ-012 i_Resp_Ready  input  2  SHALL carry the per-requester response accept.

Function
REQ-013 Block SHALL contain exactly one compare datapath, shared between two requesters, with the codebase encoding: EQ, NE, LTU, GEU unsigned; LT, GE signed two's-complement; any other select yields result 0.
REQ-014 Request handshake SHALL fire for requester r when i_Req_Valid[r] && o_Req_Ready[r]; at most one fires per cycle.
REQ-015 Requester r SHALL be eligible when i_Req_Valid[r] is high and its response slot is empty, or is full and i_Resp_Ready[r] is high in the same cycle (drain-and-refill bypass).
REQ-016 o_Req_Ready SHALL be combinational from registered state, i_Req_Valid and i_Resp_Ready only; it SHALL NOT depend on operands or select.
REQ-017 Arbitration SHALL be round-robin with a 1-bit priority state: PRI0 (requester 0 wins ties) and PRI1 (requester 1 wins ties).
REQ-018 If only one requester is eligible, it SHALL be granted regardless of priority state.
REQ-019 After a grant to requester r, priority state SHALL move to favour the other requester; without a grant, it SHALL hold.
REQ-020 On the edge ending a grant cycle, the compare result for the granted operands SHALL be written into slot r with o_Resp_Valid[r]=1 (latency 1 cycle, grant to response).
REQ-021 Slot r SHALL hold o_Resp_Valid[r] and o_Resp_Result[r] stable until i_Resp_Ready[r] is high; on that edge, it SHALL clear unless refilled per REQ-015.
REQ-022 Simultaneous drain and refill of slot r SHALL leave o_Resp_Valid[r]=1 with the new result (no bubble); sustained single-requester throughput SHALL be 1 per cycle.
REQ-023 i_Resp_Ready[r] while o_Resp_Valid[r]=0 SHALL have no effect.
REQ-024 Operands and select SHALL be sampled only in the grant cycle; later changes SHALL NOT alter a stored result.

Reset
REQ-025 While i_Reset=1 at an edge, o_Resp_Valid SHALL become 2'b00, o_Resp_Result 2'b00, and priority state PRI0; pending results SHALL be discarded.
REQ-026 While i_Reset=1, o_Req_Ready SHALL be 2'b00 and no grant SHALL fire.
REQ-027 In the first cycle after reset deassertion, requests SHALL be eligible per REQ-015.

Verification
REQ-028 Single request: r0 A=5, B=7, select LTU, resp ready held high -> Req_Ready[0]=1 in cycle N; Resp_Valid[0]=1, Result[0]=1 in N+1; Resp_Valid[0]=0 in N+2.
REQ-029 Signed vs unsigned: A=32'hFFFF_FFFF, B=1: LT -> result 1; LTU -> result 0; GE -> 0; GEU -> 1; invalid select 3'b111 -> 0.
REQ-030 Contention: both valid every cycle, both resp ready high, from reset -> grants alternate r0, r1, r0, r1; each requester receives a response every second cycle.
REQ-031 Backpressure: r1 Resp_Ready=0 with slot full, r1 valid -> r1 never granted and r1 result/valid held stable; r0 still granted each cycle; raising Resp_Ready[1] -> r1 granted that same cycle, new result the next.
REQ-032 Reset mid-operation: slot 0 full, priority PRI1, assert i_Reset one cycle -> Resp_Valid=00, Result=00; with both valid after release, r0 granted first.

Source files
------------

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle for cmp_arbiter: two requesters share one compare unit.
// slave = arbiter side, master = requester/response-consumer side.
interface cmp_arbiter_if #(
  parameter int XLEN          = 32,
  parameter int CMP_SEL_WIDTH = 2
);
  logic [1:0]                     i_Req_Valid;
  logic [1:0]                     o_Req_Ready;
  logic [2*XLEN-1:0]              i_Req_A;
  logic [2*XLEN-1:0]              i_Req_B;
  logic [2*(CMP_SEL_WIDTH+1)-1:0] i_Req_Select;
  logic [1:0]                     o_Resp_Valid;
  logic [1:0]                     o_Resp_Result;
  logic [1:0]                     i_Resp_Ready;

  modport slave (
    input  i_Req_Valid,
    output o_Req_Ready,
    input  i_Req_A,
    input  i_Req_B,
    input  i_Req_Select,
    output o_Resp_Valid,
    output o_Resp_Result,
    input  i_Resp_Ready
  );

  modport master (
    output i_Req_Valid,
    input  o_Req_Ready,
    output i_Req_A,
    output i_Req_B,
    output i_Req_Select,
    input  o_Resp_Valid,
    input  o_Resp_Result,
    output i_Resp_Ready
  );
endinterface

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter in front of one shared compare unit.
// Ports: i_Clock, i_Reset (sync, active-high), bus (cmp_arbiter_if.slave).
module cmp_arbiter #(
  parameter int XLEN          = 32,
  parameter int CMP_SEL_WIDTH = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  cmp_arbiter_if.slave bus
);

  localparam int SW = CMP_SEL_WIDTH + 1;

  // Select encoding; codes 6 and above give 0.
  localparam logic [SW-1:0] SEL_EQ  = SW'(0);
  localparam logic [SW-1:0] SEL_NE  = SW'(1);
  localparam logic [SW-1:0] SEL_LT  = SW'(2);
  localparam logic [SW-1:0] SEL_LTU = SW'(3);
  localparam logic [SW-1:0] SEL_GE  = SW'(4);
  localparam logic [SW-1:0] SEL_GEU = SW'(5);

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  pri_e            pri;
  logic [1:0]      slot_vld;
  logic [1:0]      slot_res;
  logic [1:0]      elig;
  logic [1:0]      grant;
  logic            pick1;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [SW-1:0]   op_sel;
  logic            cmp_res;

  // A full slot can still accept when it drains in the same cycle.
  assign elig = bus.i_Req_Valid
              & (~slot_vld | bus.i_Resp_Ready)
              & {2{~i_Reset}};

  always_comb begin
    grant = elig;
    if (&elig) begin
      grant = (pri == PRI0) ? 2'b01 : 2'b10;
    end
  end

  assign pick1  = grant[1];
  assign op_a   = pick1 ? bus.i_Req_A[XLEN +: XLEN]
                        : bus.i_Req_A[0 +: XLEN];
  assign op_b   = pick1 ? bus.i_Req_B[XLEN +: XLEN]
                        : bus.i_Req_B[0 +: XLEN];
  assign op_sel = pick1 ? bus.i_Req_Select[SW +: SW]
                        : bus.i_Req_Select[0 +: SW];

  always_comb begin
    cmp_res = 1'b0;
    case (op_sel)
      SEL_EQ:  cmp_res = (op_a == op_b);
      SEL_NE:  cmp_res = (op_a != op_b);
      SEL_LT:  cmp_res = ($signed(op_a) < $signed(op_b));
      SEL_LTU: cmp_res = (op_a < op_b);
      SEL_GE:  cmp_res = ($signed(op_a) >= $signed(op_b));
      SEL_GEU: cmp_res = (op_a >= op_b);
      default: cmp_res = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      pri      <= PRI0;
      slot_vld <= 2'b00;
      slot_res <= 2'b00;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (grant[r]) begin
          slot_vld[r] <= 1'b1;
          slot_res[r] <= cmp_res;
        end else if (bus.i_Resp_Ready[r]) begin
          slot_vld[r] <= 1'b0;
        end
      end
      if (grant[0]) begin
        pri <= PRI1;
      end else if (grant[1]) begin
        pri <= PRI0;
      end
    end
  end

  assign bus.o_Req_Ready   = grant;
  assign bus.o_Resp_Valid  = slot_vld;
  assign bus.o_Resp_Result = slot_res;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Testbench for cmp_arbiter: vector table, scoreboard of responses,
// and directed contention / backpressure / reset sequences.
module tb_cmp_arbiter;

  localparam logic [2:0] EQ  = 3'd0;
  localparam logic [2:0] NE  = 3'd1;
  localparam logic [2:0] LT  = 3'd2;
  localparam logic [2:0] LTU = 3'd3;
  localparam logic [2:0] GE  = 3'd4;
  localparam logic [2:0] GEU = 3'd5;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic sb0[$];
  logic sb1[$];

  cmp_arbiter_if #(.XLEN(32), .CMP_SEL_WIDTH(2)) bus ();

  cmp_arbiter #(.XLEN(32), .CMP_SEL_WIDTH(2)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_cmp(logic [31:0] a, logic [31:0] b,
                                   logic [2:0] s);
    case (s)
      EQ:      return a == b;
      NE:      return a != b;
      LT:      return $signed(a) < $signed(b);
      LTU:     return a < b;
      GE:      return $signed(a) >= $signed(b);
      GEU:     return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int r, logic [31:0] a, logic [31:0] b,
                         logic [2:0] s);
    bus.i_Req_A[r*32 +: 32]     = a;
    bus.i_Req_B[r*32 +: 32]     = b;
    bus.i_Req_Select[r*3 +: 3]  = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    logic e;
    if (rst) begin
      sb0.delete();
      sb1.delete();
    end else begin
      if (bus.o_Resp_Valid[0] && bus.i_Resp_Ready[0]) begin
        if (sb0.size() == 0) check("sb_r0_unexpected", 1, 0);
        else begin
          e = sb0.pop_front();
          check("sb_r0", 32'(bus.o_Resp_Result[0]), 32'(e));
        end
      end
      if (bus.o_Resp_Valid[1] && bus.i_Resp_Ready[1]) begin
        if (sb1.size() == 0) check("sb_r1_unexpected", 1, 0);
        else begin
          e = sb1.pop_front();
          check("sb_r1", 32'(bus.o_Resp_Result[1]), 32'(e));
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (bus.i_Req_Valid[r] && bus.o_Req_Ready[r]) begin
          e = ref_cmp(bus.i_Req_A[r*32 +: 32], bus.i_Req_B[r*32 +: 32],
                      bus.i_Req_Select[r*3 +: 3]);
          if (r == 0) sb0.push_back(e);
          else        sb1.push_back(e);
        end
      end
    end
  end

  vec_t vt[12];

  initial begin
    checks = 0;
    errors = 0;
    vt[0]  = '{EQ,   32'd5,          32'd5,          1'b1};
    vt[1]  = '{EQ,   32'd5,          32'd7,          1'b0};
    vt[2]  = '{NE,   32'd5,          32'd7,          1'b1};
    vt[3]  = '{LTU,  32'd5,          32'd7,          1'b1};
    vt[4]  = '{LT,   32'hFFFF_FFFF,  32'd1,          1'b1};
    vt[5]  = '{LTU,  32'hFFFF_FFFF,  32'd1,          1'b0};
    vt[6]  = '{GE,   32'hFFFF_FFFF,  32'd1,          1'b0};
    vt[7]  = '{GEU,  32'hFFFF_FFFF,  32'd1,          1'b1};
    vt[8]  = '{3'd7, 32'hFFFF_FFFF,  32'd1,          1'b0};
    vt[9]  = '{3'd6, 32'd5,          32'd5,          1'b0};
    vt[10] = '{GE,   32'd7,          32'd7,          1'b1};
    vt[11] = '{LT,   32'h8000_0000,  32'h7FFF_FFFF,  1'b1};

    bus.i_Req_Valid  = 2'b11;
    bus.i_Req_A      = '0;
    bus.i_Req_B      = '0;
    bus.i_Req_Select = '0;
    bus.i_Resp_Ready = 2'b11;
    rst = 1'b1;

    // No grant while reset is held.
    @(negedge clk);
    check("rst_ready", 32'(bus.o_Req_Ready), 0);
    step();
    step();
    rst = 1'b0;
    bus.i_Req_Valid = 2'b00;
    @(negedge clk);
    check("rst_resp_valid", 32'(bus.o_Resp_Valid), 0);
    check("rst_result", 32'(bus.o_Resp_Result), 0);

    // Vector table on requester 0, resp ready held high.
    for (int i = 0; i < 12; i++) begin
      step();
      set_req(0, vt[i].a, vt[i].b, vt[i].sel);
      bus.i_Req_Valid = 2'b01;
      @(negedge clk);
      check($sformatf("vec%0d_grant", i), 32'(bus.o_Req_Ready), 1);
      step();
      bus.i_Req_Valid = 2'b00;
      set_req(0, ~vt[i].a, vt[i].b, vt[i].sel);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(bus.o_Resp_Valid), 1);
      check($sformatf("vec%0d_res", i), 32'(bus.o_Resp_Result[0]),
            32'(vt[i].exp));
      step();
      @(negedge clk);
      check($sformatf("vec%0d_clear", i), 32'(bus.o_Resp_Valid), 0);
    end

    // Contention: grants alternate from PRI0.
    step();
    do_reset();
    bus.i_Resp_Ready = 2'b11;
    bus.i_Req_Valid  = 2'b11;
    for (int k = 0; k < 8; k++) begin
      set_req(0, $urandom, $urandom, 3'($urandom_range(0, 7)));
      set_req(1, $urandom, $urandom, 3'($urandom_range(0, 7)));
      @(negedge clk);
      check($sformatf("rr_grant%0d", k), 32'(bus.o_Req_Ready),
            (k % 2 == 0) ? 1 : 2);
      if (k > 0)
        check($sformatf("rr_valid%0d", k), 32'(bus.o_Resp_Valid),
              ((k - 1) % 2 == 0) ? 1 : 2);
      step();
    end

    // Backpressure on requester 1.
    bus.i_Req_Valid = 2'b00;
    do_reset();
    bus.i_Resp_Ready = 2'b01;
    bus.i_Req_Valid  = 2'b10;
    set_req(1, 32'd3, 32'd9, LTU);
    @(negedge clk);
    check("bp_first_grant", 32'(bus.o_Req_Ready), 2);
    step();
    bus.i_Req_Valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      set_req(1, 32'd9 + 32'(j), 32'd3, LTU);
      set_req(0, $urandom, $urandom, 3'($urandom_range(0, 7)));
      @(negedge clk);
      check($sformatf("bp_grant%0d", j), 32'(bus.o_Req_Ready), 1);
      check($sformatf("bp_hold_v%0d", j), 32'(bus.o_Resp_Valid[1]), 1);
      check($sformatf("bp_hold_r%0d", j), 32'(bus.o_Resp_Result[1]), 1);
      step();
    end
    bus.i_Resp_Ready = 2'b11;
    set_req(1, 32'd9, 32'd3, LTU);
    @(negedge clk);
    check("bp_release_grant", 32'(bus.o_Req_Ready), 2);
    step();
    bus.i_Req_Valid = 2'b00;
    @(negedge clk);
    check("bp_new_valid", 32'(bus.o_Resp_Valid[1]), 1);
    check("bp_new_res", 32'(bus.o_Resp_Result[1]), 0);

    // Reset in the middle: slot 0 full, priority favouring r1.
    step();
    do_reset();
    bus.i_Resp_Ready = 2'b00;
    bus.i_Req_Valid  = 2'b01;
    set_req(0, 32'd1, 32'd1, EQ);
    @(negedge clk);
    check("mr_grant", 32'(bus.o_Req_Ready), 1);
    step();
    bus.i_Req_Valid = 2'b00;
    @(negedge clk);
    check("mr_full", 32'(bus.o_Resp_Valid), 1);
    check("mr_full_res", 32'(bus.o_Resp_Result), 1);
    rst = 1'b1;
    bus.i_Req_Valid = 2'b11;
    @(negedge clk);
    check("mr_rst_ready", 32'(bus.o_Req_Ready), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mr_valid", 32'(bus.o_Resp_Valid), 0);
    check("mr_res", 32'(bus.o_Resp_Result), 0);
    check("mr_first_grant", 32'(bus.o_Req_Ready), 1);
    step();

    // Drain everything; scoreboard must be empty.
    bus.i_Req_Valid  = 2'b00;
    bus.i_Resp_Ready = 2'b11;
    step();
    step();
    step();
    @(negedge clk);
    check("sb_drained", 32'(sb0.size() + sb1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
